// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: divider FSM encodings and default datapath width.
package cpu_defs_pkg;

    localparam int unsigned DIV_WIDTH   = 32;
    localparam int unsigned DIV_STATE_W = 2;

    localparam logic [DIV_STATE_W-1:0] DIV_IDLE = 2'd0;
    localparam logic [DIV_STATE_W-1:0] DIV_BUSY = 2'd1;
    localparam logic [DIV_STATE_W-1:0] DIV_DONE = 2'd2;

endpackage

// File: rtl/div_sequencer_step.sv
// One restoring shift-subtract iteration of the unsigned divider datapath.
module div_step
    import cpu_defs_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] r_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] r_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    assign shifted = {r_i, q_i[WIDTH-1]};
    assign diff    = shifted - {1'b0, d_i};

    always_comb begin
        r_o = WIDTH'(shifted);
        q_o = {q_i[WIDTH-2:0], 1'b0};
        if (shifted >= {1'b0, d_i}) begin
            r_o = WIDTH'(diff);
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU controller for the E stage: FSM, operand/sign capture, fix-up.
// Optional DIV_ZERO_FAST_EN: divide-by-zero goes IDLE -> DONE without iterating.
module div_sequencer
    import cpu_defs_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             cancel,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem,
    output logic             busy
);

    logic [DIV_STATE_W-1:0] state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]       r_q, r_d;
    logic [WIDTH-1:0]       q_q, q_d;
    logic [WIDTH-1:0]       dvs_q, dvs_d;
    logic [WIDTH-1:0]       opa_q, opa_d;
    logic                   neg_quot_q, neg_quot_d;
    logic                   neg_rem_q, neg_rem_d;
    logic                   zero_q, zero_d;
    logic                   done_q, done_d;
    logic [WIDTH-1:0]       quot_q, quot_d;
    logic [WIDTH-1:0]       rem_q, rem_d;
    logic                   stall_c;

    logic [WIDTH-1:0]       opa_abs, opb_abs;
    logic [WIDTH-1:0]       step_r, step_q;

    function automatic logic [WIDTH-1:0] neg_if(input logic neg, input logic [WIDTH-1:0] x);
        return neg ? (WIDTH'(0) - x) : x;
    endfunction

    assign opa_abs = neg_if(signed_op & opa[WIDTH-1], opa);
    assign opb_abs = neg_if(signed_op & opb[WIDTH-1], opb);

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_i (r_q),
        .q_i (q_q),
        .d_i (dvs_q),
        .r_o (step_r),
        .q_o (step_q)
    );

    // Next-state, datapath update and stall; cancel overrides everything.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        r_d        = r_q;
        q_d        = q_q;
        dvs_d      = dvs_q;
        opa_d      = opa_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        zero_d     = zero_q;
        done_d     = 1'b0;
        quot_d     = quot_q;
        rem_d      = rem_q;
        stall_c    = 1'b0;

        case (state_q)
            DIV_IDLE: begin
                if (start && !cancel) begin
                    stall_c    = 1'b1;
                    q_d        = opa_abs;
                    dvs_d      = opb_abs;
                    opa_d      = opa;
                    r_d        = '0;
                    cnt_d      = '0;
                    neg_quot_d = signed_op & (opa[WIDTH-1] ^ opb[WIDTH-1]);
                    neg_rem_d  = signed_op & opa[WIDTH-1];
                    zero_d     = (opb == '0);
`ifdef DIV_ZERO_FAST_EN
                    if (opb == '0) begin
                        state_d = DIV_DONE;
                        done_d  = 1'b1;
                        quot_d  = '1;
                        rem_d   = opa;
                    end else begin
                        state_d = DIV_BUSY;
                    end
`else
                    state_d    = DIV_BUSY;
`endif
                end
            end
            DIV_BUSY: begin
                if (cancel) begin
                    state_d = DIV_IDLE;
                end else begin
                    stall_c = 1'b1;
                    r_d     = step_r;
                    q_d     = step_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = DIV_DONE;
                        done_d  = 1'b1;
                        quot_d  = zero_q ? '1    : neg_if(neg_quot_q, step_q);
                        rem_d   = zero_q ? opa_q : neg_if(neg_rem_q, step_r);
                    end
                end
            end
            DIV_DONE: begin
                state_d = DIV_IDLE;
            end
            default: begin
                state_d = DIV_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= DIV_IDLE;
            cnt_q      <= '0;
            r_q        <= '0;
            q_q        <= '0;
            dvs_q      <= '0;
            opa_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_q     <= '0;
            rem_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            r_q        <= r_d;
            q_q        <= q_d;
            dvs_q      <= dvs_d;
            opa_q      <= opa_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            zero_q     <= zero_d;
            done_q     <= done_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
        end
    end

    // Stall is combinational, so reset must mask it to keep all outputs low.
    assign stall = stall_c & resetn;
    assign done  = done_q;
    assign quot  = quot_q;
    assign rem   = rem_q;
    assign busy  = (state_q != DIV_IDLE);

    a_start_held: assert property (
        @(posedge clk) disable iff (!resetn)
        (state_q == DIV_BUSY && !cancel) |-> start
    );

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: results, stall/done latency, cancel and reset.
module tb_div_sequencer;

    localparam int unsigned W = 32;

    logic         clk;
    logic         resetn;
    logic         start;
    logic         signed_op;
    logic [W-1:0] opa;
    logic [W-1:0] opb;
    logic         cancel;
    logic         stall;
    logic         done;
    logic [W-1:0] quot;
    logic [W-1:0] rem;
    logic         busy;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
    } res_t;

    res_t sb[$];
    int   n_checks = 0;
    int   n_err    = 0;
    logic [W-1:0] last_q = '0;
    logic [W-1:0] last_r = '0;

    div_sequencer dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .signed_op (signed_op),
        .opa       (opa),
        .opb       (opb),
        .cancel    (cancel),
        .stall     (stall),
        .done      (done),
        .quot      (quot),
        .rem       (rem),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic res_t model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
        res_t   res;
        longint sa, sbv;
        if (b == '0) begin
            res.q = '1;
            res.r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            res.q = 32'h8000_0000;
            res.r = '0;
        end else if (s) begin
            sa    = longint'($signed(a));
            sbv   = longint'($signed(b));
            res.q = W'(sa / sbv);
            res.r = W'(sa % sbv);
        end else begin
            res.q = a / b;
            res.r = a % b;
        end
        return res;
    endfunction

    // Issue one operation, hold start until done, check latency and result.
    task automatic run_op(input string tag, input logic s, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int   stall_cnt = 0;
        int   done_cyc  = 0;
        int   exp_stall = W + 1;
        int   exp_done  = W + 2;
        res_t exp_res;
        res_t got_res;
`ifdef DIV_ZERO_FAST_EN
        if (b == '0) begin
            exp_stall = 1;
            exp_done  = 2;
        end
`endif
        @(negedge clk);
        start     = 1'b1;
        signed_op = s;
        opa       = a;
        opb       = b;
        sb.push_back(model(s, a, b));
        for (int cyc = 1; cyc <= 60 && done_cyc == 0; cyc++) begin
            #1;
            if (stall) stall_cnt++;
            if (done) begin
                done_cyc = cyc;
                if (sb.size() == 0) begin
                    check({tag, "_sb_empty"}, 64'd1, 64'd0);
                end else begin
                    exp_res = sb.pop_front();
                    got_res = '{q: quot, r: rem};
                    check({tag, "_quot"}, 64'(got_res.q), 64'(exp_res.q));
                    check({tag, "_rem"},  64'(got_res.r), 64'(exp_res.r));
                    last_q = exp_res.q;
                    last_r = exp_res.r;
                end
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_done_seen"},  64'(done_cyc != 0), 64'd1);
        check({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
        check({tag, "_stall_cnt"},  64'(stall_cnt), 64'(exp_stall));
        // start still high through DONE; the following cycle must be idle
        @(negedge clk);
        #1;
        check({tag, "_no_relaunch"}, 64'(busy), 64'd0);
        check({tag, "_done_pulse"},  64'(done), 64'd0);
        start = 1'b0;
    endtask

    initial begin
        resetn    = 1'b0;
        start     = 1'b0;
        signed_op = 1'b0;
        opa       = '0;
        opb       = '0;
        cancel    = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", 64'(stall), 64'd0);
        check("rst_done",  64'(done),  64'd0);
        check("rst_quot",  64'(quot),  64'd0);
        check("rst_rem",   64'(rem),   64'd0);
        check("rst_busy",  64'(busy),  64'd0);
        @(negedge clk);
        resetn = 1'b1;

        run_op("divu_100_7",  1'b0, 32'd100,         32'd7);
        run_op("div_m7_2",    1'b1, 32'hFFFF_FFF9,   32'd2);
        run_op("div_7_m2",    1'b1, 32'd7,           32'hFFFF_FFFE);
        run_op("div_ovf",     1'b1, 32'h8000_0000,   32'hFFFF_FFFF);
        run_op("divu_5_0",    1'b0, 32'd5,           32'd0);
        run_op("div_m5_0",    1'b1, 32'hFFFF_FFFB,   32'd0);
        run_op("divu_rand",   1'b0, $urandom(),      $urandom_range(1, 1000));

        // Cancel in the tenth BUSY cycle: stall drops immediately, no result.
        @(negedge clk);
        start     = 1'b1;
        signed_op = 1'b0;
        opa       = 32'd1000;
        opb       = 32'd3;
        repeat (10) @(negedge clk);
        cancel = 1'b1;
        #1;
        check("cancel_busy_before", 64'(busy),  64'd1);
        check("cancel_stall",       64'(stall), 64'd0);
        @(negedge clk);
        cancel = 1'b0;
        start  = 1'b0;
        #1;
        check("cancel_idle", 64'(busy), 64'd0);
        check("cancel_done", 64'(done), 64'd0);
        check("cancel_quot", 64'(quot), 64'(last_q));
        check("cancel_rem",  64'(rem),  64'(last_r));
        run_op("divu_9_3", 1'b0, 32'd9, 32'd3);

        // Asynchronous reset mid-operation.
        @(negedge clk);
        start     = 1'b1;
        signed_op = 1'b0;
        opa       = 32'd77;
        opb       = 32'd5;
        repeat (5) @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_stall", 64'(stall), 64'd0);
        check("arst_done",  64'(done),  64'd0);
        check("arst_quot",  64'(quot),  64'd0);
        check("arst_rem",   64'(rem),   64'd0);
        check("arst_busy",  64'(busy),  64'd0);
        start = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        run_op("divu_1_1",   1'b0, 32'd1,         32'd1);
        run_op("divu_big16", 1'b0, 32'hFFFF_FFFF, 32'd16);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Multi-cycle integer divider controller and iterative datapath for MIPS DIV/DIVU in the E stage.
- Generates the divider stall that the hazard unit uses to freeze F/D/E/M/W.
- Produces HI (remainder) and LO (quotient) for the E-stage instruction.
- Aborts cleanly when an M-stage exception flushes the pipeline.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  pipeline clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  E-stage holds a valid DIV/DIVU; held stable while stall=1
- signed_op  in  1  1 = DIV (signed), 0 = DIVU
- opa  in  WIDTH  dividend (rs)
- opb  in  WIDTH  divisor (rt)
- cancel  in  1  pipeline flush (M_except); aborts the operation
- stall  out  1  divider stall to the hazard unit (E_div_stall)
- done  out  1  one-cycle pulse: quot/rem valid
- quot  out  WIDTH  quotient, to LO
- rem  out  WIDTH  remainder, to HI
- busy  out  1  state != IDLE (debug/perf)

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; counter=0; internal regs=0.
  - stall=0, done=0, quot=0, rem=0, busy=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - stall = start & ~cancel, combinational, in the issue cycle.
  - On start & ~cancel:
    - Latch |opa| and |opb| (abs only when signed_op).
    - Latch sign_q = signed_op & (opa[W-1]^opb[W-1]) and sign_r = signed_op & opa[W-1].
    - Latch zero_div = (opb==0).
    - Clear the partial remainder; counter=0; go to BUSY.
- BUSY:
  - stall=1 unless cancel.
  - Each cycle performs one restoring shift-subtract step:
    - {R,Q} <<= 1.
    - If R >= D: R -= D, Q[0] = 1.
  - counter++; after WIDTH steps (counter==WIDTH-1 at the step edge) go to DONE.
- DONE (exactly one cycle):
  - stall=0, done=1; the pipeline advances on this edge.
  - quot = sign_q ? -Q : Q; rem = sign_r ? -R : R.
  - Next state is IDLE unconditionally; start still high in DONE must NOT re-launch.
- Latency:
  - Stall is high for WIDTH+1 cycles (the issue cycle plus WIDTH BUSY cycles).
  - done is asserted in cycle WIDTH+2, counting the issue cycle as cycle 1.
- quot/rem are registered and hold their value after DONE until the next DONE.
- Divide by zero (zero_div): quot = all ones, rem = opa (original value), sign fix bypassed; latency unchanged.
- Overflow 0x80000000 / -1 (signed): quot = 0x80000000, rem = 0; falls out of the datapath naturally.
- cancel:
  - Highest priority in every state.
  - Forces stall=0 combinationally in the same cycle.
  - Next state is IDLE; no done pulse; quot/rem unchanged.
- start dropping in BUSY without cancel is illegal; an assertion must flag it.
- resetn low mid-operation: immediate return to the reset state.

Optional Feature:
- DIV_ZERO_FAST_EN defined:
  - zero_div skips BUSY: IDLE → DONE directly.
  - Stall lasts only the issue cycle; done arrives in the next cycle with the divide-by-zero results above.
- DIV_ZERO_FAST_EN undefined: divide by zero takes the full WIDTH+1 stall cycles.

Decomposition:
- Shared package (cpu_defs_pkg):
  - state enum DIV_IDLE/DIV_BUSY/DIV_DONE.
  - DIV_WIDTH=32 constant.
- Sub-module div_step (combinational):
  - Inputs: R, Q, D.
  - Outputs: next R, next Q for one restoring iteration.
- div_sequencer owns the FSM, counter, operand and sign registers, and the sign fix-up.

Test Plan:
- DIVU 100/7:
  - stall high for 33 cycles.
  - done in cycle 34 with quot=14, rem=2.
  - start held through DONE causes no relaunch.
- DIV -7/2 (0xFFFFFFF9 / 2): quot=0xFFFFFFFD (-3), rem=0xFFFFFFFF (-1). DIV 7/-2: quot=-3, rem=1.
- DIV 0x80000000 / 0xFFFFFFFF: quot=0x80000000, rem=0, no hang.
- DIVU 5/0:
  - quot=0xFFFFFFFF, rem=5.
  - Full latency without the macro; with DIV_ZERO_FAST_EN, done in cycle 2.
- cancel pulsed in BUSY cycle 10:
  - stall=0 in that cycle; state IDLE next cycle; no done; quot/rem keep their previous values.
  - A new DIVU 9/3 issued immediately afterwards gives quot=3, rem=0.
- resetn asserted low in BUSY: all outputs 0 asynchronously. After release, back-to-back DIVU 1/1 then 0xFFFFFFFF/16 gives (1,0) then (0x0FFFFFFF, 15).
